tpu_host_seq: RTL and testbench
===============================

// Module: tpu_host_seq
// PURPOSE
//  Host-side bus master for the memory-mapped TPU (r_w/addr/dataIn/dataOut bus).
//  Accepts a job as a 64-bit word stream (DIM A rows, then DIM B rows) and writes it to the TPU.
//  Issues the MATMUL command, waits a fixed compute time, then reads C back as an output word stream.
//  Sits between the host/DMA stream fabric and the tpuv1 top.
// PARAMETERS
//  BITS_AB     8       A/B element width
//  BITS_C      16      C element width
//  DIM         8       matrix dimension; DIM*BITS_AB==DATAW and DIM*BITS_C==2*DATAW are required
//  ADDRW       16      TPU address width
//  DATAW       64      TPU data / stream word width
//  MUL_CYCLES  24      cycles waited after MATMUL before the first C read (>=3*DIM-2)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  start      in   1      1-cycle job request; sampled in IDLE only
//  busy       out  1      high from the cycle after an accepted start until DONE
//  done       out  1      1-cycle pulse when the last C word has been accepted
//  in_valid   in   1      input word valid
//  in_ready   out  1      input word ready
//  in_data    in   DATAW  A/B row word; element k at bits [k*BITS_AB +: BITS_AB]
//  out_valid  out  1      C word valid
//  out_ready  in   1      C word ready
//  out_data   out  DATAW  C half-row word
//  out_last   out  1      marks the final C word (row DIM-1, high half)
//  tpu_r_w    out  1      0=read, 1=write
//  tpu_addr   out  ADDRW  TPU byte address
//  tpu_wdata  out  DATAW  drives TPU dataIn
//  tpu_rdata  in   DATAW  from TPU dataOut; valid 1 cycle after a read address is driven
// BEHAVIOUR
//  Address map:
//   - A row r: 0x0100+8r
//   - B row r: 0x0200+8r
//   - C row r: 0x0300+16r (low word) and 0x0300+16r+8 (high word)
//   - MATMUL: write to 0x0400, data 0
//  Reset: state IDLE; all outputs 0, including the tpu_* bus. Idle bus is r_w=0, addr=0, wdata=0.
//  All outputs are registered.
//  States:
//   - IDLE: start -> LOAD_A; row counter cleared.
//   - LOAD_A: in_ready=1. Each accepted word (in_valid&in_ready) produces exactly one bus write cycle on
//     the next cycle: r_w=1, addr=0x0100+8*row, wdata=in_data. row++. After row DIM-1 -> LOAD_B, row=0.
//     Cycles with no accepted word drive the idle bus.
//   - LOAD_B: same as LOAD_A at 0x0200. After row DIM-1 -> MUL.
//   - MUL: one bus write cycle, addr=0x0400, wdata=0 -> WAIT.
//   - WAIT: idle bus for MUL_CYCLES cycles (down-counter) -> RD_LO, row=0.
//   - RD_LO: drive r_w=0, addr=0x0300+16*row for 1 cycle -> CAP_LO.
//   - CAP_LO: register tpu_rdata into out_data, out_valid=1 -> HOLD_LO.
//   - HOLD_LO: hold out_data until out_ready -> RD_HI.
//   - RD_HI / CAP_HI / HOLD_HI: same as the LO states at addr+8. out_last=1 when row==DIM-1.
//     On the handshake: row<DIM-1 -> row++, RD_LO; else -> DONE.
//   - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Stream rules:
//   - in_ready is 0 in every state except LOAD_A/LOAD_B.
//   - out_data and out_last stay stable while out_valid=1 and out_ready=0.
//   - out_valid drops the cycle after the handshake.
//  Boundary cases:
//   - start outside IDLE is ignored.
//   - in_valid outside the LOAD states is ignored; no bus activity results.
//   - Exactly 2*DIM input words are consumed per job; extra words wait for the next job.
//   - Exactly 2*DIM output words are produced per job.
//   - rst_n low at any point (e.g. mid-WAIT or while holding out_valid) immediately returns IDLE with all
//     outputs 0. A partial job is discarded and no done is issued.
//   - The last A word and the first B word may be accepted back-to-back; no bubble is required.
// TESTING
//  1. Reset: hold rst_n=0 -> busy, done, in_ready, out_valid, tpu_r_w all 0; tpu_addr=0.
//  2. Full job, in_valid always 1:
//     - A rows 0x0101..0x0808 -> writes to 0x0100..0x0138, then B writes to 0x0200..0x0238.
//     - Then one write to 0x0400; 24 idle cycles.
//     - Then reads 0x0300, 0x0308 .. 0x0370, 0x0378 in order.
//     - The TPU model returns addr as data -> out_data matches each read addr; out_last only on the 16th word;
//       done pulses once.
//  3. Input gaps: in_valid high every third cycle -> same 16 write addresses/data in order, idle bus between.
//  4. Output backpressure: out_ready low 5 cycles on word 3 -> out_data held constant; no new read issued
//     until the handshake.
//  5. start pulsed during LOAD_B and WAIT -> ignored; exactly one done per job.
//  6. rst_n asserted in WAIT cycle 10 -> IDLE next edge, all outputs 0. A new start then gives a clean full
//     job (same result as scenario 2).

Source files
------------

// File: rtl/tpu_host_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_host_seq_if : job stream, result stream and TPU bus bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface tpu_host_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  // Host/DMA fabric and TPU side of the sequencer.
  modport master (
    output start, in_valid, in_data, out_ready, tpu_rdata,
    input  busy, done, in_ready, out_valid, out_data, out_last,
           tpu_r_w, tpu_addr, tpu_wdata
  );

  // The sequencer itself.
  modport slave (
    input  start, in_valid, in_data, out_ready, tpu_rdata,
    output busy, done, in_ready, out_valid, out_data, out_last,
           tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface
`default_nettype wire

// File: rtl/tpu_host_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_host_seq : loads A/B rows onto the TPU bus, fires MATMUL, streams C out.
// Rev 1.0
// ---------------------------------------------------------------------------
module tpu_host_seq #(
  parameter int BITS_AB    = 8,
  parameter int BITS_C     = 16,
  parameter int DIM        = 8,
  parameter int ADDRW      = 16,
  parameter int DATAW      = 64,
  parameter int MUL_CYCLES = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  tpu_host_seq_if.slave bus
);

  localparam int ROWW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CNTW = $clog2(MUL_CYCLES + 1);

  localparam logic [ROWW-1:0]  ROW_LAST = ROWW'(DIM - 1);
  localparam logic [CNTW-1:0]  CNT_LOAD = CNTW'(MUL_CYCLES);
  localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE   = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE   = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MUL_ADDR = ADDRW'(16'h0400);
  localparam logic [ADDRW-1:0] HI_OFS   = ADDRW'(8);

  generate
    if ((DIM * BITS_AB != DATAW) || (DIM * BITS_C != 2 * DATAW) ||
        (MUL_CYCLES < 3 * DIM - 2)) begin : g_param_check
      $error("tpu_host_seq: inconsistent DIM/BITS_AB/BITS_C/DATAW/MUL_CYCLES");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_MUL, S_WAIT,
    S_RD_LO, S_CAP_LO, S_HOLD_LO,
    S_RD_HI, S_CAP_HI, S_HOLD_HI, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ROWW-1:0]  row_q, row_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             r_w_q, r_w_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] wdata_q, wdata_d;

  logic             w_accept;
  logic [ROWW-1:0]  w_row_inc;
  logic [ADDRW-1:0] w_row_x8;
  logic [ADDRW-1:0] w_row_x16;
  logic [ADDRW-1:0] w_inc_x16;

  assign w_accept  = bus.in_valid & in_ready_q;
  assign w_row_inc = row_q + ROWW'(1);
  assign w_row_x8  = ADDRW'(row_q) << 3;
  assign w_row_x16 = ADDRW'(row_q) << 4;
  assign w_inc_x16 = ADDRW'(w_row_inc) << 4;

  // Bus fields default to the idle pattern; each state only asserts what it drives next cycle.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    r_w_d       = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD_A;
          row_d      = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        if (w_accept) begin
          r_w_d   = 1'b1;
          addr_d  = ((state_q == S_LOAD_A) ? A_BASE : B_BASE) + w_row_x8;
          wdata_d = bus.in_data;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (state_q == S_LOAD_A) begin
              state_d = S_LOAD_B;
            end else begin
              state_d    = S_MUL;
              in_ready_d = 1'b0;
            end
          end else begin
            row_d = w_row_inc;
          end
        end
      end

      S_MUL: begin
        r_w_d   = 1'b1;
        addr_d  = MUL_ADDR;
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end

      // The first WAIT cycle carries the MATMUL write, so one extra count keeps
      // MUL_CYCLES idle cycles before the first read address.
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RD_LO;
          row_d   = '0;
          addr_d  = C_BASE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_RD_LO: state_d = S_CAP_LO;

      S_CAP_LO: begin
        out_data_d  = bus.tpu_rdata;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = S_HOLD_LO;
      end

      S_HOLD_LO: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = C_BASE + w_row_x16 + HI_OFS;
          state_d     = S_RD_HI;
        end
      end

      S_RD_HI: state_d = S_CAP_HI;

      S_CAP_HI: begin
        out_data_d  = bus.tpu_rdata;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == ROW_LAST);
        state_d     = S_HOLD_HI;
      end

      S_HOLD_HI: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (row_q != ROW_LAST) begin
            row_d   = w_row_inc;
            addr_d  = C_BASE + w_inc_x16;
            state_d = S_RD_LO;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      r_w_q       <= r_w_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.tpu_r_w   = r_w_q;
  assign bus.tpu_addr  = addr_q;
  assign bus.tpu_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_host_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tpu_host_seq : job-scenario table driven against a bus/stream scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tpu_host_seq;
  localparam int DATAW = 64;
  localparam int ADDRW = 16;
  localparam int DIM   = 8;
  localparam int NW    = 2 * DIM;
  localparam int MULC  = 24;

  typedef struct {
    int gap;       // idle in_valid cycles after each accepted word
    int bp_word;   // output word index held off by out_ready=0 (-1: none)
    int bp_len;    // valid cycles to hold that word
    bit glitch;    // pulse start during LOAD_B and WAIT
    int rst_at;    // assert rst_n at this WAIT idle cycle (0: none)
    int exp_done;  // done pulses expected for the job
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_host_seq_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  tpu_host_seq #(
    .BITS_AB(8), .BITS_C(16), .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .MUL_CYCLES(MULC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // TPU model: read data is the read address, one cycle later.
  always @(posedge clk) bus.tpu_rdata <= bus.tpu_r_w ? '0 : DATAW'(bus.tpu_addr);

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int rd_k = 0;
  int out_k = 0;
  int idle_cnt = 0;
  bit mul_seen = 1'b0;
  bit prev_hs = 1'b0;
  bit prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [79:0] wq[$];
  logic [63:0] oq[$];
  logic [79:0] w_e;
  logic [15:0] w_ea;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] row_word(input int i);
    if (i < DIM) return 64'h0101 * 64'(i + 1);
    else         return 64'hB0B0_0000_0000_0000 + 64'(i);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(bus.busy), 64'd0);
    check({tag, "_done"},      64'(bus.done), 64'd0);
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_last"},  64'(bus.out_last), 64'd0);
    check({tag, "_out_data"},  bus.out_data, 64'd0);
    check({tag, "_tpu_r_w"},   64'(bus.tpu_r_w), 64'd0);
    check({tag, "_tpu_addr"},  64'(bus.tpu_addr), 64'd0);
    check({tag, "_tpu_wdata"}, bus.tpu_wdata, 64'd0);
  endtask

  // Scoreboard: expected writes queued on accepted input words, expected C words on reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete();
      oq.delete();
      acc_cnt   = 0;
      rd_k      = 0;
      out_k     = 0;
      idle_cnt  = 0;
      mul_seen  = 1'b0;
      prev_hs   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.tpu_r_w) begin
        check("wr_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          w_e = wq.pop_front();
          check("wr_addr", 64'(bus.tpu_addr), 64'(w_e[79:64]));
          check("wr_data", bus.tpu_wdata, w_e[63:0]);
          if (w_e[79:64] == 16'h0400) begin
            mul_seen = 1'b1;
            idle_cnt = 0;
          end
        end
      end else if (bus.tpu_addr != '0) begin
        w_ea = 16'h0300 + 16'(8 * rd_k);
        check("rd_addr", 64'(bus.tpu_addr), 64'(w_ea));
        if (rd_k == 0) check("mul_wait", 64'(idle_cnt), 64'(MULC));
        check("rd_during_hold", 64'(bus.out_valid), 64'd0);
        oq.push_back(64'(w_ea));
        rd_k++;
      end else if (mul_seen && rd_k == 0) begin
        idle_cnt++;
      end

      if (prev_hs) check("valid_drop", 64'(bus.out_valid), 64'd0);
      if (prev_hold && bus.out_valid) begin
        check("hold_data", bus.out_data, prev_data);
        check("hold_last", 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", 64'(oq.size() != 0), 64'd1);
        if (oq.size() != 0) check("out_data", bus.out_data, oq.pop_front());
        check("out_last", 64'(bus.out_last), 64'(out_k == NW - 1));
        check("busy_while_out", 64'(bus.busy), 64'd1);
        out_k++;
      end
      prev_hs   = bus.out_valid && bus.out_ready;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;

      if (bus.done) begin
        done_cnt++;
        check("done_words", 64'(out_k), 64'(NW));
        check("done_busy", 64'(bus.busy), 64'd0);
        out_k    = 0;
        rd_k     = 0;
        acc_cnt  = 0;
        mul_seen = 1'b0;
      end

      if (bus.in_valid && bus.in_ready) begin
        w_ea = (acc_cnt < DIM) ? 16'h0100 + 16'(8 * acc_cnt)
                               : 16'h0200 + 16'(8 * (acc_cnt - DIM));
        wq.push_back({w_ea, bus.in_data});
        acc_cnt++;
        if (acc_cnt == NW) wq.push_back({16'h0400, 64'd0});
      end
    end
  end

  task automatic run_job(input int idx, input vec_t v);
    int fed = 0;
    int gap = 0;
    int bp_cnt = 0;
    int cyc = 0;
    int d0;
    bit g_load = 1'b0;
    bit g_wait = 1'b0;
    bit aborted = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    while (done_cnt == d0 && cyc < 3000) begin
      bus.start = 1'b0;
      if (fed < NW && gap == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = row_word(fed);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = !(out_k == v.bp_word && bp_cnt < v.bp_len);
      if (v.glitch && !g_load && acc_cnt >= DIM + 2) begin
        bus.start = 1'b1;
        g_load    = 1'b1;
      end
      if (v.glitch && !g_wait && mul_seen && idle_cnt == 5) begin
        bus.start = 1'b1;
        g_wait    = 1'b1;
      end
      if (v.rst_at > 0 && mul_seen && idle_cnt == v.rst_at) begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid_wait");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        fed++;
        gap = v.gap;
      end else if (!bus.in_valid && gap > 0) begin
        gap--;
      end
      if (!bus.out_ready && bus.out_valid) bp_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("job%0d_ended", idx), 64'(aborted || done_cnt != d0), 64'd1);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    // Words offered while idle must stay unconsumed and off the bus.
    repeat (8) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hDEAD_BEEF_0000_0000 | 64'(idx);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("job%0d_done_count", idx), 64'(done_cnt - d0), 64'(v.exp_done));
    if (!aborted) begin
      check($sformatf("job%0d_wq_empty", idx), 64'(wq.size()), 64'd0);
      check($sformatf("job%0d_oq_empty", idx), 64'(oq.size()), 64'd0);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{0, -1, 0, 1'b0, 0,  1};  // full job, in_valid always high
    vecs[1] = '{2, -1, 0, 1'b0, 0,  1};  // in_valid every third cycle
    vecs[2] = '{0,  3, 5, 1'b0, 0,  1};  // word 3 held for 5 cycles
    vecs[3] = '{1, -1, 0, 1'b1, 0,  1};  // stray starts in LOAD_B and WAIT
    vecs[4] = '{0, -1, 0, 1'b0, 10, 0};  // reset in WAIT cycle 10
    vecs[5] = '{0, -1, 0, 1'b0, 0,  1};  // clean job after the reset

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
